bitstream_byte_feeder: RTL

- Upstream stage of the arithmetic decoder. Buffers the coded slice bytestream from a source (file reader or memory streamer) in a small FIFO.
- Serves the decoder's one-byte-per-request fetch protocol: decoder `request_byte` in, `data` / `data_ready` out.
- Decouples source latency from decoder demand, flags starvation, and optionally strips VVC emulation-prevention bytes.

---
 rtl/bitstream_byte_feeder_if.sv | 11 +
 rtl/bitstream_byte_feeder.sv | 82 ++++++++
 2 files changed

// File: rtl/bitstream_byte_feeder_if.sv
// bitstream_byte_feeder_if: source push channel and decoder byte-fetch channel.
interface bitstream_byte_feeder_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       request;
    logic [7:0] data;
    logic       data_ready;
    modport master (output in_data, output in_valid, input in_ready, output request, input data, input data_ready);
    modport slave (input in_data, input in_valid, output in_ready, input request, output data, output data_ready);
endinterface

// File: rtl/bitstream_byte_feeder.sv
// bitstream_byte_feeder: byte FIFO between slice source and arithmetic decoder.
// Define EPB_STRIP_EN to drop 00 00 03 emulation-prevention bytes on push.
module bitstream_byte_feeder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    bitstream_byte_feeder_if.slave bus,
    output logic [ADDR_W:0]       level,
    output logic                  underflow,
    output logic [15:0]           epb_count
);
    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    state_t            state, state_nx;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              empty, accept, drop, wr, serve;
    assign empty          = level == '0;
    assign bus.in_ready   = level != FULL;
    assign accept         = bus.in_valid && bus.in_ready && !flush;
    assign wr             = accept && !drop;
    assign serve          = (bus.request || state == WAIT) && !empty;
    assign bus.data_ready = state == OUT;
    // WAIT doubles as the pending flag, OUT as the data_ready strobe
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        state_nx = flush ? IDLE :
                   serve ? OUT :
                   (bus.request && empty) ? WAIT :
                   state == OUT ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            underflow <= 1'b0;
            bus.data  <= 8'h00;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            underflow <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (serve) begin
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                bus.data <= mem[rd_ptr];
            end
            level <= level + (ADDR_W+1)'(wr) - (ADDR_W+1)'(serve);
            if (bus.request && state == WAIT && empty) underflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= bus.in_data;
    end
`ifdef EPB_STRIP_EN
    logic [1:0] zero_run;
    assign drop = bus.in_data == 8'h03 && zero_run == 2'd2;
    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_run  <= '0;
            epb_count <= '0;
        end else if (flush) begin
            zero_run <= '0;
        end else if (accept) begin
            zero_run <= bus.in_data != 8'h00 ? 2'd0 : zero_run == 2'd2 ? 2'd2 : zero_run + 2'd1;
            if (drop && epb_count != 16'hFFFF) epb_count <= epb_count + 16'd1;
        end
    end
`else
    assign drop      = 1'b0;
    assign epb_count = '0;
`endif
endmodule
